uart_baud_gen: RTL and testbench

UART_BAUD_GEN -- requirements
Module: uart_baud_gen

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_baud_gen_if.sv | 23 ++
 rtl/uart_frac_accum.sv | 32 +++
 rtl/uart_baud_gen.sv | 144 ++++++++++++++
 tb/tb_uart_baud_gen.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared constants and state type for the UART baud tick generator.
package uart_pkg;

    // Smallest divisor that still leaves at least one idle cycle between ticks.
    localparam int MIN_DIV        = 2;

    localparam int DEF_DIV_WIDTH  = 16;
    localparam int DEF_FRAC_BITS  = 4;
    localparam int DEF_OVERSAMPLE = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } baud_state_t;

endpackage

// File: rtl/uart_baud_gen_if.sv
// Divisor request bus: the master proposes a divisor, the generator accepts or rejects it.
interface uart_baud_gen_if #(
    parameter int DIV_WIDTH = uart_pkg::DEF_DIV_WIDTH,
    parameter int FRAC_BITS = uart_pkg::DEF_FRAC_BITS
);

    logic [DIV_WIDTH-1:0] div_int;
    logic [FRAC_BITS-1:0] div_frac;
    logic                 div_load;
    logic                 div_ack;
    logic                 div_err;

    modport master (
        output div_int, div_frac, div_load,
        input  div_ack, div_err
    );

    modport slave (
        input  div_int, div_frac, div_load,
        output div_ack, div_err
    );

endinterface

// File: rtl/uart_frac_accum.sv
// Fractional divisor accumulator: carry-out tells the caller to stretch the next period by one cycle.
module uart_frac_accum
    import uart_pkg::*;
#(
    parameter int FRAC_BITS = DEF_FRAC_BITS
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 step,
    input  logic [FRAC_BITS-1:0] frac,
    output logic                 carry
);

    logic [FRAC_BITS-1:0] acc;
    logic [FRAC_BITS:0]   sum;

    assign sum   = {1'b0, acc} + {1'b0, frac};
    assign carry = sum[FRAC_BITS];

    // Accumulate the fraction once per tick; wraps modulo 2^FRAC_BITS.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (step) begin
            acc <= sum[FRAC_BITS-1:0];
        end
    end

endmodule

// File: rtl/uart_baud_gen.sv
// Fractional baud tick generator: os_tick at the oversample rate, bit_tick every OVERSAMPLE os_ticks.
// Ticks are clock-enable pulses; new divisors take effect only at a period reload.
//
// state | meaning
// IDLE  | enable low; outputs quiet, pending divisor copied straight to active
// RUN   | counting down; tick and reload when the count reads zero
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DIV_WIDTH        = DEF_DIV_WIDTH,
    parameter int FRAC_BITS        = DEF_FRAC_BITS,
    parameter int OVERSAMPLE       = DEF_OVERSAMPLE,
    parameter int DEFAULT_DIV_INT  = 651,
    parameter int DEFAULT_DIV_FRAC = 1
) (
    input  logic           clk_in,
    input  logic           reset,
    input  logic           enable,
    input  logic           sync_clear,
    uart_baud_gen_if.slave div_bus,
    output logic           os_tick,
    output logic           bit_tick
);

    localparam int                   IDX_W    = $clog2(OVERSAMPLE);
    localparam logic [DIV_WIDTH-1:0] RST_INT  = DIV_WIDTH'(DEFAULT_DIV_INT);
    localparam logic [FRAC_BITS-1:0] RST_FRAC = FRAC_BITS'(DEFAULT_DIV_FRAC);
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(OVERSAMPLE - 1);
    localparam logic [DIV_WIDTH-1:0] ONE      = DIV_WIDTH'(1);

    baud_state_t          state;
    logic [DIV_WIDTH-1:0] cnt;
    logic [DIV_WIDTH-1:0] act_int;
    logic [DIV_WIDTH-1:0] sh_int;
    logic [DIV_WIDTH-1:0] nxt_int;
    logic [DIV_WIDTH-1:0] tick_reload;
    logic [FRAC_BITS-1:0] act_frac;
    logic [FRAC_BITS-1:0] sh_frac;
    logic [FRAC_BITS-1:0] nxt_frac;
    logic [IDX_W-1:0]     idx;
    logic                 pending;
    logic                 req_ok;
    logic                 carry;
    logic                 start;
    logic                 resync;

    assign req_ok = div_bus.div_load && (div_bus.div_int >= DIV_WIDTH'(MIN_DIV));

    // Divisor to use at the next reload: a request arriving this cycle beats an older shadow.
    always_comb begin
        nxt_int  = act_int;
        nxt_frac = act_frac;
        if (req_ok) begin
            nxt_int  = div_bus.div_int;
            nxt_frac = div_bus.div_frac;
        end else if (pending) begin
            nxt_int  = sh_int;
            nxt_frac = sh_frac;
        end
    end

    assign start    = (state == IDLE) && enable;
    assign resync   = (state == RUN) && enable && sync_clear;
    assign os_tick  = (state == RUN) && enable && !sync_clear && (cnt == '0);
    assign bit_tick = os_tick && (idx == IDX_LAST);

    // Fraction carry stretches the following period to D+1 cycles.
    assign tick_reload = nxt_int - ONE + DIV_WIDTH'(carry);

    uart_frac_accum #(
        .FRAC_BITS (FRAC_BITS)
    ) u_frac_accum (
        .clk_in (clk_in),
        .reset  (reset),
        .clear  (start || resync),
        .step   (os_tick),
        .frac   (nxt_frac),
        .carry  (carry)
    );

    // Sequencer: period counter, oversample index and divisor shadowing.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            act_int  <= RST_INT;
            act_frac <= RST_FRAC;
            sh_int   <= RST_INT;
            sh_frac  <= RST_FRAC;
            pending  <= 1'b0;
        end else begin
            if (req_ok) begin
                sh_int  <= div_bus.div_int;
                sh_frac <= div_bus.div_frac;
                pending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    act_int  <= nxt_int;
                    act_frac <= nxt_frac;
                    pending  <= 1'b0;
                    if (enable) begin
                        state <= RUN;
                        cnt   <= nxt_int - ONE;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (sync_clear) begin
                        cnt      <= nxt_int - ONE;
                        idx      <= '0;
                        act_int  <= nxt_int;
                        act_frac <= nxt_frac;
                        pending  <= 1'b0;
                    end else if (cnt == '0) begin
                        cnt      <= tick_reload;
                        idx      <= idx + IDX_W'(1);
                        act_int  <= nxt_int;
                        act_frac <= nxt_frac;
                        pending  <= 1'b0;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Request response: one-cycle accept or reject pulse after div_load.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            div_bus.div_ack <= 1'b0;
            div_bus.div_err <= 1'b0;
        end else begin
            div_bus.div_ack <= req_ok;
            div_bus.div_err <= div_bus.div_load && !req_ok;
        end
    end

endmodule

// File: tb/tb_uart_baud_gen.sv
// Self-checking bench for uart_baud_gen: vector table, randomized divisors against a
// closed-form tick-time model, and hand-written sequences for load/sync/reset corners.
module tb_uart_baud_gen;
    import uart_pkg::*;

    localparam int DW       = 16;
    localparam int FB       = 4;
    localparam int FRAC_ONE = 1 << FB;
    localparam int OS       = 16;

    logic clk_in     = 1'b0;
    logic reset      = 1'b1;
    logic enable     = 1'b0;
    logic sync_clear = 1'b0;
    logic os_tick;
    logic bit_tick;

    uart_baud_gen_if #(.DIV_WIDTH(DW), .FRAC_BITS(FB)) bus ();

    uart_baud_gen #(
        .DIV_WIDTH        (DW),
        .FRAC_BITS        (FB),
        .OVERSAMPLE       (OS),
        .DEFAULT_DIV_INT  (651),
        .DEFAULT_DIV_FRAC (1)
    ) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .enable     (enable),
        .sync_clear (sync_clear),
        .div_bus    (bus),
        .os_tick    (os_tick),
        .bit_tick   (bit_tick)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;
    int os_t[$];
    int bit_t[$];
    int ack_t[$];
    int err_t[$];

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        if (os_tick)     os_t.push_back(cyc);
        if (bit_tick)    bit_t.push_back(cyc);
        if (bus.div_ack) ack_t.push_back(cyc);
        if (bus.div_err) err_t.push_back(cyc);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required < 2000000", $time);
        $fatal(1, "watchdog");
    end

    typedef struct {
        int d;
        int f;
        int first;
        int span;
        int bit1;
    } vec_t;

    vec_t vecs[6];

    // Ideal tick k (1-based) after enable: k whole periods plus the carries accumulated so far.
    function automatic int exp_tick(int d, int f, int k);
        return k * d + ((k - 1) * f) / FRAC_ONE;
    endfunction

    function automatic int os_at(int i);
        return (i < os_t.size()) ? os_t[i] : -1;
    endfunction

    function automatic int bit_at(int i);
        return (i < bit_t.size()) ? bit_t[i] : -1;
    endfunction

    task automatic check(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d required %0d", name, act, exp);
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic clear_q();
        os_t.delete();
        bit_t.delete();
        ack_t.delete();
        err_t.delete();
    endtask

    task automatic wait_os(int n, int budget, string name);
        int b = 0;
        while (os_t.size() < n && b < budget) begin
            step(1);
            b++;
        end
        check({name, " tick arrival"}, int'(os_t.size() >= n), 1);
    endtask

    task automatic goto_cycle(int t);
        while (cyc < t) step(1);
    endtask

    task automatic load(int d, int f);
        bus.div_int  = DW'(d);
        bus.div_frac = FB'(f);
        bus.div_load = 1'b1;
        step(1);
        bus.div_load = 1'b0;
    endtask

    initial begin
        int t_en, s, s2, n0, tn, l;
        int d, f;

        vecs[0] = '{4,  0,  4,  64,  64};
        vecs[1] = '{4,  8,  4,  72,  71};
        vecs[2] = '{2,  0,  2,  32,  32};
        vecs[3] = '{3, 15,  3,  63,  62};
        vecs[4] = '{10, 1, 10, 161, 160};
        vecs[5] = '{7,  4,  7, 116, 115};

        // Reset: outputs stay quiet even with enable and a load request present.
        bus.div_int  = DW'(5);
        bus.div_frac = '0;
        bus.div_load = 1'b1;
        enable       = 1'b1;
        step(3);
        check("reset os_tick", int'(os_tick), 0);
        check("reset bit_tick", int'(bit_tick), 0);
        check("reset div_ack", int'(bus.div_ack), 0);
        check("reset div_err", int'(bus.div_err), 0);
        bus.div_load = 1'b0;
        enable       = 1'b0;
        reset        = 1'b0;
        step(2);

        // Default divisor 651 + 1/16.
        clear_q();
        enable = 1'b1;
        t_en   = cyc;
        wait_os(17, 12000, "defaults");
        check("default first tick", os_at(0) - t_en, 651);
        check("default tick 17", os_at(16) - t_en, 11068);
        check("default bit_tick count", bit_t.size(), 1);
        check("default bit_tick time", bit_at(0) - t_en, 10416);
        enable = 1'b0;
        step(2);

        // Vector table: load in IDLE, then measure first tick, 16-period span and first bit_tick.
        for (int i = 0; i < 6; i++) begin
            clear_q();
            load(vecs[i].d, vecs[i].f);
            step(2);
            check($sformatf("vec%0d ack", i), ack_t.size(), 1);
            clear_q();
            enable = 1'b1;
            t_en   = cyc;
            wait_os(17, 17 * (vecs[i].d + 1) + 20, $sformatf("vec%0d", i));
            check($sformatf("vec%0d first", i), os_at(0) - t_en, vecs[i].first);
            check($sformatf("vec%0d span", i), os_at(16) - os_at(0), vecs[i].span);
            check($sformatf("vec%0d bit_tick", i), bit_at(0) - t_en, vecs[i].bit1);
            enable = 1'b0;
            step(2);
        end

        // Randomized divisors against the closed-form model.
        for (int r = 0; r < 8; r++) begin
            d = int'($urandom_range(2, 24));
            f = int'($urandom_range(0, FRAC_ONE - 1));
            clear_q();
            load(d, f);
            step(2);
            clear_q();
            enable = 1'b1;
            t_en   = cyc;
            wait_os(20, 20 * (d + 1) + 20, $sformatf("rand%0d", r));
            for (int k = 1; k <= 20; k++)
                check($sformatf("rand%0d d=%0d f=%0d tick%0d", r, d, f, k), os_at(k - 1) - t_en, exp_tick(d, f, k));
            check($sformatf("rand%0d bit_tick count", r), bit_t.size(), 1);
            check($sformatf("rand%0d bit_tick time", r), bit_at(0) - t_en, exp_tick(d, f, OS));
            enable = 1'b0;
            step(2);
        end

        // Rejected load keeps period 4; accepted mid-period load applies after the current period.
        clear_q();
        load(4, 0);
        step(2);
        clear_q();
        enable = 1'b1;
        wait_os(2, 30, "reject setup");
        l = cyc;
        load(1, 0);
        wait_os(4, 30, "reject run");
        check("reject err cycle", (err_t.size() > 0) ? err_t[0] : -1, l + 1);
        check("reject no ack", ack_t.size(), 0);
        check("reject period a", os_at(2) - os_at(1), 4);
        check("reject period b", os_at(3) - os_at(2), 4);
        l = cyc;
        load(8, 0);
        wait_os(6, 40, "accept run");
        check("accept ack cycle", (ack_t.size() > 0) ? ack_t[0] : -1, l + 1);
        check("accept err count", err_t.size(), 1);
        check("accept old period completes", os_at(4) - os_at(3), 4);
        check("accept new period", os_at(5) - os_at(4), 8);

        // Dropping enable on a would-be tick cycle silences it immediately.
        tn = os_at(5) + 8;
        goto_cycle(tn);
        enable = 1'b0;
        #2;
        check("enable low kills tick", int'(os_tick), 0);
        step(12);
        check("no ticks while idle", os_t.size(), 6);

        // sync_clear on the zero-count cycle suppresses the tick and restarts phase and index.
        clear_q();
        load(4, 0);
        step(2);
        clear_q();
        enable = 1'b1;
        t_en   = cyc;
        wait_os(3, 30, "sync setup");
        s = t_en + 16;
        goto_cycle(s);
        sync_clear = 1'b1;
        #2;
        check("sync suppresses tick", int'(os_tick), 0);
        step(1);
        sync_clear = 1'b0;
        wait_os(19, 120, "sync run");
        check("sync tick 3 before", os_at(2) - t_en, 12);
        check("sync next tick", os_at(3) - s, 4);
        check("sync bit_tick count", bit_t.size(), 1);
        check("sync bit_tick time", bit_at(0) - s, 64);

        // div_load together with sync_clear: the new divisor applies at this resync.
        ack_t.delete();
        s2 = cyc;
        n0 = os_t.size();
        bus.div_int  = DW'(6);
        bus.div_frac = '0;
        bus.div_load = 1'b1;
        sync_clear   = 1'b1;
        step(1);
        bus.div_load = 1'b0;
        sync_clear   = 1'b0;
        wait_os(n0 + 2, 40, "load+sync");
        check("load+sync ack", (ack_t.size() > 0) ? ack_t[0] : -1, s2 + 1);
        check("load+sync first tick", os_at(n0) - s2, 6);
        check("load+sync second tick", os_at(n0 + 1) - s2, 12);

        // Reset on a tick cycle with a freshly accepted load pending.
        tn = os_at(n0 + 1) + 6;
        goto_cycle(tn - 1);
        bus.div_int  = DW'(9);
        bus.div_frac = '0;
        bus.div_load = 1'b1;
        step(1);
        bus.div_load = 1'b0;
        check("pre-reset tick", int'(os_tick), 1);
        reset = 1'b1;
        #1;
        check("async reset os_tick", int'(os_tick), 0);
        check("async reset bit_tick", int'(bit_tick), 0);
        check("async reset div_ack", int'(bus.div_ack), 0);
        step(2);
        clear_q();
        reset = 1'b0;
        t_en  = cyc;
        wait_os(1, 700, "post-reset");
        check("post-reset default period", os_at(0) - t_en, 651);
        check("post-reset no ack", ack_t.size(), 0);
        check("post-reset no err", err_t.size(), 0);
        enable = 1'b0;
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
